// File: rtl/ysyx_22050039_idu_pipe_if.sv
// ----------------------------------------------------------------------------
// ysyx_22050039_idu_pipe_if
// Bus bundle for the decode stage: IFU-side valid/ready, EXU-side valid/ready
// with the decoded payload, and the EXU/LSU write-back port.
//   master : the environment side (drives in_*, out_ready, wb_*)
//   slave  : the decode stage (drives in_ready and the out_* bundle)
// ----------------------------------------------------------------------------
interface ysyx_22050039_idu_pipe_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned REG_SEL = 5
);
    // IFU side
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_inst;
    logic [XLEN-1:0]    in_pc;

    // EXU side
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [XLEN-1:0]    out_src1;
    logic [XLEN-1:0]    out_src2;
    logic [XLEN-1:0]    out_imm;
    logic [31:0]        out_inst;
    logic [REG_SEL-1:0] out_rd;
    logic [5:0]         out_type;
    logic               out_wen;
    logic               out_pc_wen;
    logic               out_ebreak;
    logic               out_illegal;

    // write-back port
    logic               wb_valid;
    logic [REG_SEL-1:0] wb_rd;
    logic [XLEN-1:0]    wb_data;

    modport master (
        output in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data,
        input  in_ready, out_valid, out_pc, out_src1, out_src2, out_imm,
               out_inst, out_rd, out_type, out_wen, out_pc_wen, out_ebreak,
               out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data,
        output in_ready, out_valid, out_pc, out_src1, out_src2, out_imm,
               out_inst, out_rd, out_type, out_wen, out_pc_wen, out_ebreak,
               out_illegal
    );
endinterface

// File: rtl/ysyx_22050039_idu_pipe.sv
// ----------------------------------------------------------------------------
// ysyx_22050039_idu_pipe
// Pipelined RV64 decode stage with integrated 32x64 register file and a
// per-register outstanding-write scoreboard. One instruction per cycle,
// stalls on RAW (sources with pending writes) and on a saturated rd counter.
// Decoded bundle is presented from a registered output stage.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ysyx_22050039_idu_pipe_if.slave (IFU handshake, EXU bundle, WB port)
//
// Optional feature macro: YSYX_22050039_IDU_BYPASS_EN
//   defined   : write-back data forwarded to same-cycle source reads; a source
//               with exactly one pending write that is being written back is
//               not a hazard.
//   undefined : no forwarding; dependents issue the cycle after write-back.
// ----------------------------------------------------------------------------
module ysyx_22050039_idu_pipe (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22050039_idu_pipe_if.slave        bus
);
    localparam int unsigned XLEN    = 64;
    localparam int unsigned NR_REG  = 32;
    localparam int unsigned REG_SEL = 5;
    localparam int unsigned SB_W    = 2;

    localparam logic [SB_W-1:0] SB_MAX = '1;
    localparam logic [31:0]     EBREAK = 32'h0010_0073;

    localparam logic [5:0] T_R = 6'b100000;
    localparam logic [5:0] T_I = 6'b010000;
    localparam logic [5:0] T_S = 6'b001000;
    localparam logic [5:0] T_B = 6'b000100;
    localparam logic [5:0] T_U = 6'b000010;
    localparam logic [5:0] T_J = 6'b000001;

    // architectural state
    logic [XLEN-1:0]    r_gpr [NR_REG];
    logic [SB_W-1:0]    r_sb  [NR_REG];

    // output stage
    logic               r_out_valid;
    logic [XLEN-1:0]    r_out_pc;
    logic [XLEN-1:0]    r_out_src1;
    logic [XLEN-1:0]    r_out_src2;
    logic [XLEN-1:0]    r_out_imm;
    logic [31:0]        r_out_inst;
    logic [REG_SEL-1:0] r_out_rd;
    logic [5:0]         r_out_type;
    logic               r_out_wen;
    logic               r_out_pc_wen;
    logic               r_out_ebreak;
    logic               r_out_illegal;

    // instruction fields
    logic [31:0]        w_inst;
    logic [6:0]         w_opcode;
    logic [REG_SEL-1:0] w_rs1;
    logic [REG_SEL-1:0] w_rs2;
    logic [REG_SEL-1:0] w_rd;

    assign w_inst   = bus.in_inst;
    assign w_opcode = w_inst[6:0];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_rd     = w_inst[11:7];

    // immediates by format
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    assign w_imm_i = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{(XLEN-12){w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{(XLEN-13){w_inst[31]}}, w_inst[31], w_inst[7],
                      w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){w_inst[31]}}, w_inst[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){w_inst[31]}}, w_inst[31], w_inst[19:12],
                      w_inst[20], w_inst[30:21], 1'b0};

    // register read and per-source busy status
    logic [SB_W-1:0] w_sb1;
    logic [SB_W-1:0] w_sb2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_busy1;
    logic            w_busy2;

    assign w_sb1 = r_sb[w_rs1];
    assign w_sb2 = r_sb[w_rs2];

`ifdef YSYX_22050039_IDU_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1    = bus.wb_valid && (bus.wb_rd == w_rs1) && (w_rs1 != '0);
    assign w_fwd2    = bus.wb_valid && (bus.wb_rd == w_rs2) && (w_rs2 != '0);
    // the last pending write landing this cycle clears the dependency
    assign w_busy1   = (w_sb1 != '0) && !(w_fwd1 && (w_sb1 == SB_W'(1)));
    assign w_busy2   = (w_sb2 != '0) && !(w_fwd2 && (w_sb2 == SB_W'(1)));
    assign w_rs1_val = w_fwd1 ? bus.wb_data :
                       ((w_rs1 == '0) ? '0 : r_gpr[w_rs1]);
    assign w_rs2_val = w_fwd2 ? bus.wb_data :
                       ((w_rs2 == '0) ? '0 : r_gpr[w_rs2]);
`else
    assign w_busy1   = (w_sb1 != '0);
    assign w_busy2   = (w_sb2 != '0);
    assign w_rs1_val = (w_rs1 == '0) ? '0 : r_gpr[w_rs1];
    assign w_rs2_val = (w_rs2 == '0) ? '0 : r_gpr[w_rs2];
`endif

    // opcode decode and operand selection
    logic [5:0]      w_type;
    logic            w_wen;
    logic            w_pc_wen;
    logic            w_ebreak;
    logic            w_illegal;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_src1;
    logic [XLEN-1:0] w_src2;

    always_comb begin
        w_type    = '0;
        w_wen     = 1'b0;
        w_pc_wen  = 1'b0;
        w_ebreak  = 1'b0;
        w_illegal = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_imm     = '0;
        w_src1    = '0;
        w_src2    = '0;
        case (w_opcode)
            7'b0110011, 7'b0111011: begin
                w_type    = T_R;
                w_wen     = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_src1    = w_rs1_val;
                w_src2    = w_rs2_val;
            end
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
                w_type    = T_I;
                w_wen     = 1'b1;
                w_pc_wen  = (w_opcode == 7'b1100111);
                w_use_rs1 = 1'b1;
                w_imm     = w_imm_i;
                w_src1    = w_rs1_val;
                w_src2    = w_imm_i;
            end
            7'b0100011: begin
                w_type    = T_S;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = w_imm_s;
                w_src1    = w_rs1_val;
                w_src2    = w_rs2_val;
            end
            7'b1100011: begin
                w_type    = T_B;
                w_pc_wen  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = w_imm_b;
                w_src1    = w_rs1_val;
                w_src2    = w_rs2_val;
            end
            7'b0110111, 7'b0010111: begin
                w_type    = T_U;
                w_wen     = 1'b1;
                w_imm     = w_imm_u;
                w_src1    = w_imm_u;
            end
            7'b1101111: begin
                w_type    = T_J;
                w_wen     = 1'b1;
                w_pc_wen  = 1'b1;
                w_imm     = w_imm_j;
                w_src1    = w_imm_j;
            end
            default: begin
                if (w_inst == EBREAK) begin
                    w_ebreak = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
        endcase
    end

    // hazard and handshake
    logic w_rd_full;
    logic w_hazard;
    logic w_in_ready_c;
    logic w_accept;
    logic w_sb_inc;

    assign w_sb_inc     = w_wen && (w_rd != '0);
    assign w_rd_full    = w_sb_inc && (r_sb[w_rd] == SB_MAX);
    assign w_hazard     = (w_use_rs1 && w_busy1) || (w_use_rs2 && w_busy2) || w_rd_full;
    assign w_in_ready_c = !rst && !w_hazard && (!r_out_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && w_in_ready_c;

    assign bus.in_ready = w_in_ready_c;

    // register file: x0 never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NR_REG; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (bus.wb_valid && (bus.wb_rd != '0)) begin
            r_gpr[bus.wb_rd] <= bus.wb_data;
        end
    end

    // scoreboard: issue increments, write-back decrements, both cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NR_REG; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NR_REG; i++) begin
                if (w_accept && w_sb_inc && (w_rd == REG_SEL'(i))) begin
                    if (!(bus.wb_valid && (bus.wb_rd == REG_SEL'(i)))) begin
                        r_sb[i] <= r_sb[i] + SB_W'(1);
                    end
                end else if (bus.wb_valid && (bus.wb_rd == REG_SEL'(i)) &&
                             (r_sb[i] != '0)) begin
                    // a write-back with nothing pending is dropped
                    r_sb[i] <= r_sb[i] - SB_W'(1);
                end
            end
        end
    end

    // output stage: load on accept, hold while stalled downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_pc      <= '0;
            r_out_src1    <= '0;
            r_out_src2    <= '0;
            r_out_imm     <= '0;
            r_out_inst    <= '0;
            r_out_rd      <= '0;
            r_out_type    <= '0;
            r_out_wen     <= 1'b0;
            r_out_pc_wen  <= 1'b0;
            r_out_ebreak  <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_pc      <= bus.in_pc;
            r_out_src1    <= w_src1;
            r_out_src2    <= w_src2;
            r_out_imm     <= w_imm;
            r_out_inst    <= w_inst;
            r_out_rd      <= w_rd;
            r_out_type    <= w_type;
            r_out_wen     <= w_wen;
            r_out_pc_wen  <= w_pc_wen;
            r_out_ebreak  <= w_ebreak;
            r_out_illegal <= w_illegal;
        end else if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_out_pc;
    assign bus.out_src1    = r_out_src1;
    assign bus.out_src2    = r_out_src2;
    assign bus.out_imm     = r_out_imm;
    assign bus.out_inst    = r_out_inst;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_type    = r_out_type;
    assign bus.out_wen     = r_out_wen;
    assign bus.out_pc_wen  = r_out_pc_wen;
    assign bus.out_ebreak  = r_out_ebreak;
    assign bus.out_illegal = r_out_illegal;

endmodule

// File: tb/tb_ysyx_22050039_idu_pipe.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050039_idu_pipe
// Table of decode vectors with hand-derived expected bundles, plus directed
// sequences for RAW/WAW stalls, output hold, x0 handling and reset. Accepted
// instructions push their expected bundle; the monitor pops on each EXU
// handshake and compares.
// ----------------------------------------------------------------------------
module tb_ysyx_22050039_idu_pipe;
    localparam logic [5:0] T_R = 6'b100000;
    localparam logic [5:0] T_I = 6'b010000;
    localparam logic [5:0] T_S = 6'b001000;
    localparam logic [5:0] T_B = 6'b000100;
    localparam logic [5:0] T_U = 6'b000010;
    localparam logic [5:0] T_J = 6'b000001;
    localparam logic [63:0] X6 = 64'h0000_0000_0000_1234;
    localparam logic [63:0] X7 = 64'hFFFF_FFFF_FFFF_FFF0;
    localparam int NVEC = 15;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] src1;
        logic [63:0] src2;
        logic [63:0] imm;
        logic [5:0]  typ;
        logic [3:0]  flg;   // {wen, pc_wen, ebreak, illegal}
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22050039_idu_pipe_if bus ();

    ysyx_22050039_idu_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    exp_t tv[NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] inst, input logic [5:0] typ,
                                input logic [3:0] flg, input logic [4:0] rd,
                                input logic [63:0] s1, input logic [63:0] s2,
                                input logic [63:0] imm);
        exp_t e;
        e.inst = inst; e.pc = '0; e.src1 = s1; e.src2 = s2; e.imm = imm;
        e.typ = typ; e.flg = flg; e.rd = rd;
        return e;
    endfunction

    // scoreboard monitor: one compare set per consumed bundle
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_bundle: got inst 0x%0h expected none", bus.out_inst);
            end else begin
                e = q.pop_front();
                chk("pc",    bus.out_pc,   e.pc);
                chk("inst",  64'(bus.out_inst), 64'(e.inst));
                chk("src1",  bus.out_src1, e.src1);
                chk("src2",  bus.out_src2, e.src2);
                chk("imm",   bus.out_imm,  e.imm);
                chk("type",  64'(bus.out_type), 64'(e.typ));
                chk("flags", 64'({bus.out_wen, bus.out_pc_wen, bus.out_ebreak, bus.out_illegal}),
                    64'(e.flg));
                if (e.flg[3]) chk("rd", 64'(bus.out_rd), 64'(e.rd));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // drive one instruction until accepted; push its expectation on accept
    task automatic issue(input exp_t e, input int max_wait, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_inst  = e.inst;
        bus.in_pc    = e.pc;
        while (!acc && waited < max_wait) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(e);
                acc = 1'b1;
            end else begin
                waited++;
            end
            cyc();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_errors++;
            $display("FAIL issue_timeout: inst 0x%0h not accepted after %0d cycles, required acceptance",
                     e.inst, waited);
        end
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [63:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
        cyc();
        bus.wb_valid = 1'b0;
    endtask

    initial begin : main
        int   w;
        exp_t e;
        logic [63:0] pc;

        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        pc = 64'h8000_0000;

        tv[0]  = mk(32'h00730533, T_R, 4'b1000, 5'd10, X6, X7, 64'h0);
        tv[1]  = mk(32'hFFF30593, T_I, 4'b1000, 5'd11, X6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        tv[2]  = mk(32'hFE733C23, T_S, 4'b0000, 5'd0,  X6, X7, 64'hFFFF_FFFF_FFFF_FFF8);
        tv[3]  = mk(32'hFE7308E3, T_B, 4'b0100, 5'd0,  X6, X7, 64'hFFFF_FFFF_FFFF_FFF0);
        tv[4]  = mk(32'h800001B7, T_U, 4'b1000, 5'd3,  64'hFFFF_FFFF_8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000);
        tv[5]  = mk(32'h12345617, T_U, 4'b1000, 5'd12, 64'h1234_5000, 64'h0, 64'h1234_5000);
        tv[6]  = mk(32'h001006EF, T_J, 4'b1100, 5'd13, 64'h800, 64'h0, 64'h800);
        tv[7]  = mk(32'hFFDFF76F, T_J, 4'b1100, 5'd14, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        tv[8]  = mk(32'h004307E7, T_I, 4'b1100, 5'd15, X6, 64'h4, 64'h4);
        tv[9]  = mk(32'hFFFFFFFF, 6'b0, 4'b0001, 5'd0, 64'h0, 64'h0, 64'h0);
        tv[10] = mk(32'h00100073, 6'b0, 4'b0010, 5'd0, 64'h0, 64'h0, 64'h0);
        tv[11] = mk(32'h0103B503, T_I, 4'b1000, 5'd10, X7, 64'h10, 64'h10);
        tv[12] = mk(32'h006305BB, T_R, 4'b1000, 5'd11, X6, X6, 64'h0);
        tv[13] = mk(32'h0013861B, T_I, 4'b1000, 5'd12, X7, 64'h1, 64'h1);
        tv[14] = mk(32'h00000073, 6'b0, 4'b0001, 5'd0, 64'h0, 64'h0, 64'h0);

        // reset state
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
            chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
            cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("post_rst_out_pc", bus.out_pc, 64'h0);
        chk("post_rst_out_src1", bus.out_src1, 64'h0);
        chk("post_rst_out_inst", 64'(bus.out_inst), 64'h0);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'h1);
        cyc();

        // preload sources, then back-to-back decode table
        wb_write(5'd6, X6);
        wb_write(5'd7, X7);
        for (int i = 0; i < NVEC; i++) begin
            e = tv[i];
            e.pc = pc;
            pc += 64'd4;
            issue(e, 8, w);
            chk("table_no_stall", 64'(w), 64'h0);
        end
        repeat (3) cyc();
        chk("table_drained", 64'(q.size()), 64'h0);

        // reset while a bundle is held: bundle dropped, scoreboard/GPRs cleared,
        // write-back during reset ignored
        bus.out_ready = 1'b0;
        issue(mk(32'h00100093, T_I, 4'b1000, 5'd1, 64'h0, 64'h1, 64'h1), 4, w);
        @(negedge clk);
        chk("held_before_rst", 64'(bus.out_valid), 64'h1);
        cyc();
        rst = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 64'h99;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_in_ready", 64'(bus.in_ready), 64'h0);
            cyc();
        end
        rst = 1'b0;
        bus.wb_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
        cyc();
        bus.out_ready = 1'b1;
        e = mk(32'h00A30833, T_R, 4'b1000, 5'd16, 64'h0, 64'h0, 64'h0);
        e.pc = 64'h100;
        issue(e, 4, w);
        chk("rst_sb_cleared", 64'(w), 64'h0);

        // RAW: addi x1,x0,5 then add x2,x1,x1
        e = mk(32'h00500093, T_I, 4'b1000, 5'd1, 64'h0, 64'h5, 64'h5);
        e.pc = 64'h200;
        issue(e, 4, w);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00108133;
        bus.in_pc    = 64'h204;
        repeat (3) begin
            @(negedge clk);
            chk("raw_stall", 64'(bus.in_ready), 64'h0);
            cyc();
        end
        e = mk(32'h00108133, T_R, 4'b1000, 5'd2, 64'h5, 64'h5, 64'h0);
        e.pc = 64'h204;
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 64'h5;
        @(negedge clk);
`ifdef YSYX_22050039_IDU_BYPASS_EN
        chk("raw_bypass_accept", 64'(bus.in_ready), 64'h1);
        if (bus.in_ready) q.push_back(e);
        cyc();
        bus.wb_valid = 1'b0;
        bus.in_valid = 1'b0;
`else
        chk("raw_wb_cycle_stall", 64'(bus.in_ready), 64'h0);
        cyc();
        bus.wb_valid = 1'b0;
        issue(e, 4, w);
        chk("raw_accept_after_wb", 64'(w), 64'h0);
`endif
        cyc();

        // output hold: lui x3 held three cycles while addi x4 waits
        bus.out_ready = 1'b0;
        e = mk(32'h800001B7, T_U, 4'b1000, 5'd3, 64'hFFFF_FFFF_8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000);
        e.pc = 64'h300;
        issue(e, 4, w);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00700213;
        bus.in_pc    = 64'h304;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", 64'(bus.in_ready), 64'h0);
            chk("hold_out_valid", 64'(bus.out_valid), 64'h1);
            chk("hold_src1", bus.out_src1, 64'hFFFF_FFFF_8000_0000);
            chk("hold_pc", bus.out_pc, 64'h300);
            cyc();
        end
        bus.out_ready = 1'b1;
        e = mk(32'h00700213, T_I, 4'b1000, 5'd4, 64'h0, 64'h7, 64'h7);
        e.pc = 64'h304;
        issue(e, 4, w);
        chk("hold_release_accept", 64'(w), 64'h0);

        // x0: write-back to x0 ignored and not forwarded; x0 writes leave no count
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 64'hDEAD;
        e = mk(32'h00000433, T_R, 4'b1000, 5'd8, 64'h0, 64'h0, 64'h0);
        e.pc = 64'h400;
        issue(e, 4, w);
        bus.wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = mk(32'h00100013, T_I, 4'b1000, 5'd0, 64'h0, 64'h1, 64'h1);
            e.pc = 64'h404 + 64'(4 * i);
            issue(e, 4, w);
            chk("x0_write_no_stall", 64'(w), 64'h0);
        end
        e = mk(32'h00200493, T_I, 4'b1000, 5'd9, 64'h0, 64'h2, 64'h2);
        e.pc = 64'h420;
        issue(e, 4, w);
        chk("x0_read_no_stall", 64'(w), 64'h0);

        // WAW saturation: fourth write to x5 waits for one write-back
        for (int i = 0; i < 3; i++) begin
            e = mk(32'h00100293, T_I, 4'b1000, 5'd5, 64'h0, 64'h1, 64'h1);
            e.pc = 64'h500 + 64'(4 * i);
            issue(e, 4, w);
            chk("waw_fill_no_stall", 64'(w), 64'h0);
        end
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00100293;
        bus.in_pc    = 64'h50C;
        repeat (2) begin
            @(negedge clk);
            chk("waw_stall", 64'(bus.in_ready), 64'h0);
            cyc();
        end
        wb_write(5'd5, 64'h55);
        e = mk(32'h00100293, T_I, 4'b1000, 5'd5, 64'h0, 64'h1, 64'h1);
        e.pc = 64'h50C;
        issue(e, 4, w);

        // drain and summarize
        for (int i = 0; i < 10 && q.size() != 0; i++) cyc();
        chk("final_drained", 64'(q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050039_idu_pipe.md
# ysyx_22050039_idu_pipe

Pipelined RV64 decode stage with an integrated register file and a per-register write scoreboard. Sits between the IFU and EXU, with a valid/ready handshake on both sides and a dedicated write-back port from the EXU/LSU. Accepts one instruction per cycle and stalls on read-after-write and write-after-write hazards. Presents decoded operands and immediates from a registered output stage.

## Interface
- XLEN, 64, datapath and register width
- NR_REG, 32, number of GPRs (x0 hardwired to zero)
- REG_SEL, 5, register index width, clog2(NR_REG)
- SB_W, 2, scoreboard counter width per register; max outstanding writes = 2^SB_W−1
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IFU has an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EXU accepts bundle
- out_pc, out_src1, out_src2, out_imm  out  XLEN  decoded PC, operands and immediate
- out_inst  out  32  raw instruction, passed through for funct decoding in the EXU
- out_rd  out  REG_SEL  destination register
- out_type  out  6  one-hot {R,I,S,B,U,J}; all zero for special/illegal
- out_wen, out_pc_wen, out_ebreak, out_illegal  out  1 each  decode flags
- wb_valid  in  1  write-back strobe
- wb_rd  in  REG_SEL  write-back index
- wb_data  in  XLEN  write-back data

## Operation
- Opcode classes (in_inst[6:0]):
  - 0110011 and 0111011 → R; out_wen=1.
  - 0010011, 0011011 and 0000011 → I; out_wen=1.
  - 1100111 → I; out_wen=1, out_pc_wen=1.
  - 0100011 → S.
  - 1100011 → B; out_pc_wen=1.
  - 0110111 and 0010111 → U; out_wen=1.
  - 1101111 → J; out_wen=1, out_pc_wen=1.
  - Exactly 0x00100073 → out_ebreak=1, out_type=0.
  - Anything else → out_illegal=1, out_type=0, out_wen=0, out_pc_wen=0.
- Operands by type (sext = sign-extend to XLEN):
  - R: src1=x[rs1], src2=x[rs2].
  - I: src1=x[rs1], src2=out_imm=sext(inst[31:20]).
  - S: src1=x[rs1], src2=x[rs2], out_imm=sext({inst[31:25],inst[11:7]}).
  - B: src1=x[rs1], src2=x[rs2], out_imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U: src1=out_imm=sext({inst[31:12],12'b0}), src2=0.
  - J: src1=out_imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}), src2=0.
  - Special/illegal: all operands 0.
- Register file: written at the edge when wb_valid is high and wb_rd≠0. x0 always reads 0; writes to x0 are discarded.
- Scoreboard: one SB_W-bit counter per register.
  - Increments on accept when out_wen=1 and rd≠0.
  - Decrements on wb_valid when wb_rd≠0.
  - Increment and decrement of the same register in one cycle → unchanged.
  - A decrement at 0 is a protocol error; the counter holds at 0.
- Hazard: stall if any source used by the type (R/S/B: rs1,rs2; I: rs1) has a nonzero counter, or if rd's counter is at its maximum.
- in_ready = !rst & !hazard & (!out_valid | out_ready).

## Timing
- Reset values: out_valid=0, every other output register 0, all GPRs 0, all scoreboard counters 0. in_ready=0 during rst.
- Latency: accept at edge N → bundle visible with out_valid=1 after edge N; one cycle.
- Register reads and hazard checks are combinational in the accept cycle.
- The output stage holds all outputs stable while out_valid & !out_ready.
- Back-to-back throughput is 1/cycle when hazard-free and out_ready=1.
- Reset mid-operation discards the output bundle and clears the scoreboard. A write-back in the rst cycle is ignored.

## Configuration
- YSYX_22050039_IDU_BYPASS_EN defined:
  - wb_data is forwarded to any source read with a matching non-zero index in the same cycle.
  - A source whose counter is 1 and which is being written back this cycle is not a hazard.
  - A dependent instruction is accepted in the write-back cycle.
- Undefined: no forwarding. The dependent instruction is accepted one cycle after the write-back edge.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with out_ready=1 → next cycle out_valid=1, out_type=I, src1=0, src2=5, out_rd=1, out_wen=1; scoreboard[1]=1.
- Then add x2,x1,x1 (0x00108133) → in_ready=0 until wb_valid, wb_rd=1, wb_data=5. With bypass: accepted in that cycle, src1=src2=5. Without: accepted the following cycle, src1=src2=5.
- out_ready=0 with a bundle held for 3 cycles → outputs unchanged, in_ready=0. Then out_ready=1 → next instruction accepted.
- wb_rd=0, wb_data=0xDEAD, then read x0 → 0. addi x0,x0,1 leaves the scoreboard all zero.
- lui x3,0x80000 (0x800001B7) → src1=0xFFFFFFFF80000000. 0xFFFFFFFF → out_illegal=1, out_wen=0. 0x00100073 → out_ebreak=1.
- Issue four writes to x5 with SB_W=2 and no write-back → fourth stalls (counter=3). One wb to x5 → fourth accepted.
